// File: rtl/mdu_ctrl_pkg.sv
// Shared opcode, state and sizing definitions for the multiply/divide sequencer.
// Also holds the helper that picks out the ops which occupy the unit for several cycles.
package mdu_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_arith_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_arith_op = 1'b1;
      default:                                is_arith_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage request and HI/LO result bundle between the pipeline and the MDU.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic              start;
  logic [3:0]        md_op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              cancel;
  logic              md_instr_d;
  logic              busy;
  logic              md_stall;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output start, md_op, A, B, cancel, md_instr_d,
    input  busy, md_stall, HI, LO
  );

  modport slave (
    input  start, md_op, A, B, cancel, md_instr_d,
    output busy, md_stall, HI, LO
  );

endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO: the result is computed at accept,
// held in pend, and committed to HI/LO when the latency countdown expires.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  mdu_ctrl_if.slave   bus
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [63:0]       pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;

  logic                     accept_s;
  logic                     div_zero_s;
  logic signed [63:0]       smul_s;
  logic        [63:0]       umul_s;
  logic signed [DATA_W-1:0] sdiv_b_s, squot_s, srem_s;
  logic        [DATA_W-1:0] udiv_b_s, uquot_s, urem_s;

  assign accept_s = bus.start & ~bus.cancel & (state_q == ST_IDLE);

  // Behavioural arithmetic; a zero divisor is replaced by 1 so the discarded result stays defined
  always_comb begin
    div_zero_s = (bus.B == 32'd0);
    sdiv_b_s   = div_zero_s ? 32'sd1 : $signed(bus.B);
    udiv_b_s   = div_zero_s ? 32'd1 : bus.B;
    smul_s     = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    umul_s     = {32'd0, bus.A} * {32'd0, bus.B};
    squot_s    = $signed(bus.A) / sdiv_b_s;
    srem_s     = $signed(bus.A) % sdiv_b_s;
    uquot_s    = bus.A / udiv_b_s;
    urem_s     = bus.A % udiv_b_s;
  end

  // Next-state: accept/move-to-HI/LO in IDLE, countdown and commit in RUN
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (bus.md_op)
            MDU_MULT: begin
              pend_d    = $unsigned(smul_s);
              pend_wr_d = 1'b1;
              count_d   = CNT_W'(MULT_CYCLES);
              state_d   = ST_RUN;
            end
            MDU_MULTU: begin
              pend_d    = umul_s;
              pend_wr_d = 1'b1;
              count_d   = CNT_W'(MULT_CYCLES);
              state_d   = ST_RUN;
            end
            MDU_DIV: begin
              pend_d    = {srem_s, squot_s};
              pend_wr_d = ~div_zero_s;
              count_d   = CNT_W'(DIV_CYCLES);
              state_d   = ST_RUN;
            end
            MDU_DIVU: begin
              pend_d    = {urem_s, uquot_s};
              pend_wr_d = ~div_zero_s;
              count_d   = CNT_W'(DIV_CYCLES);
              state_d   = ST_RUN;
            end
            MDU_MTHI: hi_d = bus.A;
            MDU_MTLO: lo_d = bus.A;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end else begin
            hi_d = hi_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, countdown, pending result and HI/LO registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_q    <= 64'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  // Stall is combinational so an MD op in ID waits even on the cycle its predecessor starts
  assign bus.md_stall = bus.md_instr_d &
                        ((state_q == ST_RUN) | (bus.start & ~bus.cancel & is_arith_op(bus.md_op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops
// compared against a 64-bit arithmetic model of HI/LO and the busy latency.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] hi_m, lo_m;

  task automatic drive_idle();
    bus.start  = 1'b0;
    bus.md_op  = 4'd0;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    bus.cancel = 1'b0;
  endtask

  // Called at a negedge; holds the request across one rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic canc);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.A      = a;
    bus.B      = b;
    bus.cancel = canc;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Reference model: architectural effect of one accepted op and its busy length.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] w;
    cyc = 0;
    case (op)
      4'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        w  = sa * sb;
        hi_m = w[63:32]; lo_m = w[31:0]; cyc = 5;
      end
      4'd2: begin
        w  = {32'd0, a} * {32'd0, b};
        hi_m = w[63:32]; lo_m = w[31:0]; cyc = 5;
      end
      4'd3: begin
        if (b != 32'd0) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa - q * sb;
          w  = q; lo_m = w[31:0];
          w  = r; hi_m = w[31:0];
        end
        cyc = 10;
      end
      4'd4: begin
        if (b != 32'd0) begin
          lo_m = a / b;
          hi_m = a % b;
        end
        cyc = 10;
      end
      4'd5: hi_m = a;
      4'd6: lo_m = a;
      default: cyc = 0;
    endcase
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    bus.md_instr_d = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (bus.HI !== 32'd0) $display("FAIL reset_hi: got %h expected 0", bus.HI); else pass_cnt++;
    chk_cnt++; if (bus.LO !== 32'd0) $display("FAIL reset_lo: got %h expected 0", bus.LO); else pass_cnt++;
    chk_cnt++; if (bus.md_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", bus.md_stall); else pass_cnt++;
    reset_n = 1'b1;
    bus.md_instr_d = 1'b0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int cyc, ec;
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    model_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, ec);
    wait_idle(cyc);
    chk_cnt++; if (cyc != 5) $display("FAIL mult_cycles: got %0d expected 5", cyc); else pass_cnt++;
    chk_cnt++; if (bus.HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", bus.HI); else pass_cnt++;
    chk_cnt++; if (bus.LO !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h expected ffffffeb", bus.LO); else pass_cnt++;
  endtask

  task automatic test_div();
    int cyc, ec;
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    model_op(MDU_DIVU, 32'd100, 32'd7, ec);
    wait_idle(cyc);
    chk_cnt++; if (cyc != 10) $display("FAIL divu_cycles: got %0d expected 10", cyc); else pass_cnt++;
    chk_cnt++; if (bus.LO !== 32'd14) $display("FAIL divu_lo: got %0d expected 14", bus.LO); else pass_cnt++;
    chk_cnt++; if (bus.HI !== 32'd2) $display("FAIL divu_hi: got %0d expected 2", bus.HI); else pass_cnt++;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    model_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, ec);
    wait_idle(cyc);
    chk_cnt++; if (bus.LO !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", bus.LO); else pass_cnt++;
    chk_cnt++; if (bus.HI !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", bus.HI); else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int cyc, ec;
    issue(MDU_MTHI, 32'h11, 32'd0, 1'b0);
    chk_cnt++; if (bus.HI !== 32'h11 || bus.busy !== 1'b0) $display("FAIL mthi: got hi=%h busy=%b expected hi=11 busy=0", bus.HI, bus.busy); else pass_cnt++;
    issue(MDU_MTLO, 32'h22, 32'd0, 1'b0);
    hi_m = 32'h11;
    lo_m = 32'h22;
    issue(MDU_DIV, 32'd5, 32'd0, 1'b0);
    model_op(MDU_DIV, 32'd5, 32'd0, ec);
    wait_idle(cyc);
    chk_cnt++; if (cyc != 10) $display("FAIL div0_cycles: got %0d expected 10", cyc); else pass_cnt++;
    chk_cnt++; if (bus.HI !== 32'h11 || bus.LO !== 32'h22) $display("FAIL div0_hilo: got %h/%h expected 00000011/00000022", bus.HI, bus.LO); else pass_cnt++;
  endtask

  task automatic test_start_in_run();
    int cyc, ec;
    issue(MDU_MULT, 32'd6, 32'd7, 1'b0);
    model_op(MDU_MULT, 32'd6, 32'd7, ec);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 2) begin
        bus.start = 1'b1; bus.md_op = MDU_MULTU; bus.A = 32'd3; bus.B = 32'd3;
      end else if (cyc == 3) begin
        bus.start = 1'b1; bus.md_op = MDU_MTHI; bus.A = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk_cnt++; if (cyc != 5) $display("FAIL run_ignore_cycles: got %0d expected 5", cyc); else pass_cnt++;
    chk_cnt++; if (bus.HI !== hi_m || bus.LO !== lo_m) $display("FAIL run_ignore_hilo: got %h/%h expected %h/%h", bus.HI, bus.LO, hi_m, lo_m); else pass_cnt++;
  endtask

  task automatic test_cancel_stall();
    int cyc, ec, bad;
    issue(MDU_MULT, 32'd3, 32'd4, 1'b1);
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL cancel_busy: got %b expected 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (bus.HI !== hi_m || bus.LO !== lo_m) $display("FAIL cancel_hilo: got %h/%h expected %h/%h", bus.HI, bus.LO, hi_m, lo_m); else pass_cnt++;
    bus.md_instr_d = 1'b1;
    bus.start = 1'b1; bus.md_op = MDU_MULT; bus.cancel = 1'b0;
    #1;
    chk_cnt++; if (bus.md_stall !== 1'b1) $display("FAIL stall_start: got %b expected 1", bus.md_stall); else pass_cnt++;
    bus.md_op = MDU_MTHI;
    #1;
    chk_cnt++; if (bus.md_stall !== 1'b0) $display("FAIL stall_mthi: got %b expected 0", bus.md_stall); else pass_cnt++;
    bus.md_op = MDU_DIV; bus.cancel = 1'b1;
    #1;
    chk_cnt++; if (bus.md_stall !== 1'b0) $display("FAIL stall_cancel: got %b expected 0", bus.md_stall); else pass_cnt++;
    issue(MDU_DIVU, 32'd50, 32'd5, 1'b0);
    model_op(MDU_DIVU, 32'd50, 32'd5, ec);
    cyc = 0; bad = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (bus.md_stall !== 1'b1) bad++;
      @(negedge clk);
    end
    chk_cnt++; if (bad != 0 || cyc != 10) $display("FAIL stall_run: got %0d unstalled of %0d expected 0 of 10", bad, cyc); else pass_cnt++;
    chk_cnt++; if (bus.md_stall !== 1'b0) $display("FAIL stall_after: got %b expected 0", bus.md_stall); else pass_cnt++;
    bus.md_instr_d = 1'b0;
  endtask

  task automatic test_async_reset();
    issue(MDU_DIV, 32'd1000, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    chk_cnt++; if (bus.busy !== 1'b1 || bus.LO !== lo_m) $display("FAIL pre_reset: got busy=%b lo=%h expected busy=1 lo=%h", bus.busy, bus.LO, lo_m); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++; if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) $display("FAIL async_reset: got busy=%b %h/%h expected 0 0/0", bus.busy, bus.HI, bus.LO); else pass_cnt++;
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(MDU_MTLO, 32'hABCD, 32'd0, 1'b0);
    chk_cnt++; if (bus.LO !== 32'hABCD || bus.HI !== 32'd0 || bus.busy !== 1'b0) $display("FAIL mtlo_after_reset: got lo=%h hi=%h busy=%b expected 0000abcd 0 0", bus.LO, bus.HI, bus.busy); else pass_cnt++;
    lo_m = 32'hABCD;
  endtask

  task automatic test_random();
    int cyc, ec;
    logic [3:0] op;
    logic [31:0] a, b;
    logic canc;
    for (int i = 0; i < 30; i++) begin
      op   = 4'($urandom_range(0, 9));
      a    = $urandom;
      b    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      canc = ($urandom_range(0, 4) == 0);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      issue(op, a, b, canc);
      if (canc) ec = 0;
      else model_op(op, a, b, ec);
      wait_idle(cyc);
      chk_cnt++; if (cyc != ec) $display("FAIL rand_cycles[%0d]: op=%0d got %0d expected %0d", i, op, cyc, ec); else pass_cnt++;
      chk_cnt++; if (bus.HI !== hi_m || bus.LO !== lo_m) $display("FAIL rand_hilo[%0d]: op=%0d a=%h b=%h got %h/%h expected %h/%h", i, op, a, b, bus.HI, bus.LO, hi_m, lo_m); else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_in_run();
    test_cancel_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
